// File: rtl/sp_fifo_pkg.sv
// Shared definitions for the single-port-RAM FIFO controller:
// output buffer depth, arbiter grant encoding and RAM depth helper.
package sp_fifo_pkg;

    localparam int unsigned OBUF_DEPTH = 3;

    typedef enum logic {
        WR = 1'b0,
        RD = 1'b1
    } grant_t;

    function automatic int unsigned fifo_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage

// File: rtl/sp_ram_fifo_ctrl_if.sv
// Push/pop valid-ready bundle of the FIFO controller; master is the
// producer/consumer side, slave is the FIFO itself.
interface sp_ram_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/sp_fifo_obuf.sv
// Small registered output FIFO that absorbs RAM read latency; head is
// always entry 0 so the visible data comes straight from a flop.
module sp_fifo_obuf
    import sp_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [1:0]            buf_count
);

    logic [DATA_WIDTH-1:0] entry [0:OBUF_DEPTH-1];
    logic [1:0]            count_q;
    logic                  do_pop;
    logic [1:0]            wr_idx;

    assign do_pop    = pop && (count_q != '0);
    assign wr_idx    = count_q - {1'b0, do_pop};
    assign head      = entry[0];
    assign buf_count = count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + {1'b0, push} - {1'b0, do_pop};
        end
    end

    // Shift on pop; the push lands behind whatever survives the shift.
    always_ff @(posedge clk) begin
        if (do_pop) begin
            entry[0] <= entry[1];
            entry[1] <= entry[2];
        end
        if (push && (wr_idx != 2'(OBUF_DEPTH))) begin
            entry[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/sp_ram_fifo_ctrl.sv
// FIFO controller in front of a single-port RAM: arbitrates push writes
// against prefetch reads and feeds a registered output buffer.
module sp_ram_fifo_ctrl
    import sp_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sp_ram_fifo_ctrl_if.slave     fifo,
    output logic [ADDR_WIDTH+1:0] count,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic                  ram_re,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    localparam int unsigned           DEPTH    = fifo_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0]   MEM_FULL = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   mem_count;
    logic                  inflight;
    grant_t                last_grant;
    logic [1:0]            buf_count;
    logic                  mem_full;
    logic                  want_rd;
    logic                  want_wr;
    logic                  grant_wr;
    logic                  grant_rd;
    logic                  pop;

    assign mem_full = (mem_count == MEM_FULL);
    // Only registered state decides whether a prefetch is wanted.
    assign want_rd  = (mem_count != '0) &&
                      (({1'b0, buf_count} + {2'b00, inflight}) < 3'(OBUF_DEPTH));
    assign want_wr  = fifo.wr_valid && !mem_full;

    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (want_wr && want_rd) begin
            if (last_grant == RD) grant_wr = 1'b1;
            else                  grant_rd = 1'b1;
        end else begin
            grant_wr = want_wr;
            grant_rd = want_rd;
        end
    end

    assign fifo.wr_ready = rst_n && !mem_full &&
                           !(want_rd && ((last_grant == WR) || !fifo.wr_valid));

    assign ram_we   = rst_n && grant_wr;
    assign ram_re   = rst_n && grant_rd;
    assign ram_addr = grant_wr ? wr_ptr : rd_ptr;
    assign ram_data = fifo.wr_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mem_count  <= '0;
            inflight   <= 1'b0;
            last_grant <= RD;
        end else begin
            if (grant_wr) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (grant_rd) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            case ({grant_wr, grant_rd})
                2'b10:   mem_count <= mem_count + (ADDR_WIDTH+1)'(1);
                2'b01:   mem_count <= mem_count - (ADDR_WIDTH+1)'(1);
                default: mem_count <= mem_count;
            endcase
            inflight <= grant_rd;
            if (want_wr && want_rd) last_grant <= grant_wr ? WR : RD;
        end
    end

    assign fifo.rd_valid = (buf_count != '0);
    assign pop           = fifo.rd_valid && fifo.rd_ready;

    sp_fifo_obuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (ram_q),
        .pop       (pop),
        .head      (fifo.rd_data),
        .buf_count (buf_count)
    );

    assign count = (ADDR_WIDTH+2)'(mem_count) + (ADDR_WIDTH+2)'(inflight) +
                   (ADDR_WIDTH+2)'(buf_count);
    assign empty = (count == '0);
    assign full  = mem_full;

endmodule

// File: doc/sp_ram_fifo_ctrl.md
# sp_ram_fifo_ctrl

Synchronous FIFO controller that sits directly upstream of a single-port RAM with read-enable, the SoC building-block RAM with a registered read address. It owns the RAM's data, address, write-enable and read-enable inputs and consumes its read data. Because the RAM has one port, the block arbitrates between push writes and prefetch reads, one access per cycle. It presents valid/ready push and pop interfaces, with a small registered output buffer that hides the RAM read latency.

## Interface
- DATA_WIDTH, 8, payload width.
- ADDR_WIDTH, 6, RAM address width; RAM depth DEPTH = 2**ADDR_WIDTH.
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- wr_valid  in  1  push request.
- wr_ready  out  1  push accepted this cycle when wr_valid&&wr_ready.
- wr_data  in  DATA_WIDTH  push payload.
- rd_valid  out  1  rd_data holds the oldest entry.
- rd_ready  in  1  pop when rd_valid&&rd_ready.
- rd_data  out  DATA_WIDTH  registered head of output buffer.
- count  out  ADDR_WIDTH+2  total entries held (RAM + in-flight + buffer).
- full  out  1  RAM region full (mem_count==DEPTH).
- empty  out  1  count==0.
- ram_data  out  DATA_WIDTH  to RAM data; equals wr_data.
- ram_addr  out  ADDR_WIDTH  to RAM addr.
- ram_we  out  1  to RAM we.
- ram_re  out  1  to RAM re.
- ram_q  in  DATA_WIDTH  from RAM q; valid the cycle after ram_re.

## Operation
- State: wr_ptr, rd_ptr (ADDR_WIDTH, wrap modulo DEPTH); mem_count (0..DEPTH); inflight (0/1); 3-entry output buffer with buf_count (0..3); last_grant (1 bit).
- want_rd = mem_count!=0 && buf_count+inflight<3. Registered state only; no combinational input dependence.
- want_wr = wr_valid && mem_count!=DEPTH.
- Arbitration: if only one wants, it wins. If both want, the side not granted last cycle wins. last_grant updates only on a contended cycle.
- wr_ready = mem_count!=DEPTH && !(want_rd && (last_grant==WR || !wr_valid)). Its only combinational input is wr_valid, used to drop wr_ready when a read is granted.
- Write grant: ram_we=1, ram_addr=wr_ptr, wr_ptr++, mem_count++.
- Read grant: ram_re=1, ram_addr=rd_ptr, rd_ptr++, mem_count--, inflight set.
- No grant: ram_we=ram_re=0, ram_addr=rd_ptr. The RAM's held read address is unaffected.
- Capture: when inflight, ram_q is written into the output buffer at the following edge. inflight clears unless a new read is granted in the same cycle.
- A pop and a capture in the same cycle are both honoured.
- Slot reuse: a write to the slot read in the previous cycle is legal. The capture samples ram_q before the write edge takes effect.
- Ordering is strict FIFO. No bypass path from wr_data to rd_data.

## Timing
- Reset (rst_n low at an edge): pointers, mem_count, inflight, buf_count = 0; last_grant = RD, so the first contention goes to write.
- Outputs after reset: rd_valid=0, empty=1, full=0, count=0, wr_ready=1.
- While rst_n is low: ram_we=0, ram_re=0, wr_ready=0.
- Reset mid-operation discards all entries and any in-flight read. RAM contents are not cleared.
- Latency: a push accepted in cycle N yields a read grant in N+1, capture at the end of N+2, and rd_valid=1 in N+3 (empty FIFO).
- Throughput: one RAM access per cycle in total. A sustained pop stream with a backed-up RAM region yields one pop per cycle.
- Under simultaneous sustained push and pop, grants alternate, so each side gets 1/2.
- count changes by +1 on push and −1 on pop, net 0 when both occur in the same cycle. Maximum is DEPTH+3.

## Structure
- Shared package/header sp_fifo_pkg:
  - OBUF_DEPTH=3.
  - Grant encoding constants WR/RD.
  - Depth function 2**ADDR_WIDTH.
- Sub-module sp_fifo_obuf: 3-entry registered FIFO holding the output buffer.
  - Ports: push, push_data, pop, head, buf_count.
  - Head is registered.
- The top level holds the pointers, counters, arbiter and RAM-port muxing. The RAM itself is instantiated by the parent.

## Test plan
- Reset then idle: rd_valid=0, empty=1, count=0, ram_we=ram_re=0 for 10 cycles.
- Single push 0xA5 at cycle N into an empty FIFO: ram_we at N with addr 0, ram_re at N+1 with addr 0, rd_valid and rd_data=0xA5 at N+3; pop returns empty=1.
- Fill with rd_ready=0 (DEPTH=64): 67 pushes accepted (64 RAM + 3 buffer), full=1, wr_ready=0, count=67. Then drain 67 values in order with rd_ready=1.
- Contention: wr_valid=1 and rd_ready=1 continuously with a backed-up RAM region: grants alternate WR/RD each cycle, and data order is preserved across pointer wrap at 63→0.
- Slot reuse at full: write issued the cycle after a read of the same address; the popped value is the old data.
- Reset asserted with 20 entries and a read in flight: the next cycle shows count=0 and rd_valid=0. A new push 0x3C then appears first at the output.
